// File: rtl/ex_mem_reg.sv
// EX/MEM pipeline register: captures EX results, resolves branches/jumps,
// forwards WB/MEM control and counts committed redirects (saturating).
module ex_mem_reg #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             flush,
  input  logic             valid_in,
  input  logic [1:0]       WB_in,
  input  logic [3:0]       MEM_in,
  input  logic [2:0]       AluzeroCtr,
  input  logic             RegDst,
  input  logic [4:0]       Ins20_in,
  input  logic [4:0]       Ins15_in,
  input  logic [31:0]      alu_result,
  input  logic             alu_zero,
  input  logic [31:0]      B_in,
  input  logic [31:0]      nextAddress_in,
  input  logic [31:0]      imm_in,
  input  logic [25:0]      tar_in,
  output logic             valid_out,
  output logic [1:0]       WB_out,
  output logic [3:0]       MEM_out,
  output logic [31:0]      alu_result_out,
  output logic [31:0]      B_out,
  output logic [4:0]       writeReg_out,
  output logic             pcSrc_out,
  output logic [31:0]      redirect_out,
  output logic [CNT_W-1:0] taken_cnt
);

  logic        neg;
  logic        taken;
  logic        commit;
  logic [31:0] branch_target;
  logic [31:0] jump_target;
  logic [31:0] target;
  logic [4:0]  write_reg;

  assign neg = alu_result[31];

  always_comb begin
    taken = 1'b0;
    case (AluzeroCtr)
      3'b000:  taken = 1'b0;
      3'b001:  taken = alu_zero;
      3'b010:  taken = ~alu_zero;
      3'b011:  taken = alu_zero | neg;
      3'b100:  taken = ~alu_zero & ~neg;
      3'b101:  taken = neg;
      3'b110:  taken = ~neg;
      default: taken = 1'b1;
    endcase
  end

  // Target is loaded regardless of the outcome; only pcSrc_out qualifies it.
  assign branch_target = nextAddress_in + {imm_in[29:0], 2'b00};
  assign jump_target   = {nextAddress_in[31:28], tar_in, 2'b00};
  assign target        = (AluzeroCtr == 3'b111) ? jump_target : branch_target;
  assign write_reg     = RegDst ? Ins15_in : Ins20_in;
  assign commit        = taken & valid_in;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_out      <= 1'b0;
      WB_out         <= 2'b00;
      MEM_out        <= 4'b0000;
      alu_result_out <= 32'd0;
      B_out          <= 32'd0;
      writeReg_out   <= 5'd0;
      pcSrc_out      <= 1'b0;
      redirect_out   <= 32'd0;
      taken_cnt      <= '0;
    end else if (flush) begin
      valid_out      <= 1'b0;
      WB_out         <= 2'b00;
      MEM_out        <= 4'b0000;
      alu_result_out <= 32'd0;
      B_out          <= 32'd0;
      writeReg_out   <= 5'd0;
      pcSrc_out      <= 1'b0;
      redirect_out   <= 32'd0;
    end else if (!stall) begin
      // A bubble keeps its data but must never write or redirect.
      valid_out      <= valid_in;
      WB_out         <= valid_in ? WB_in : 2'b00;
      MEM_out        <= valid_in ? MEM_in : 4'b0000;
      alu_result_out <= alu_result;
      B_out          <= B_in;
      writeReg_out   <= write_reg;
      pcSrc_out      <= commit;
      redirect_out   <= target;
      if (commit && (taken_cnt != {CNT_W{1'b1}})) begin
        taken_cnt <= taken_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ex_mem_reg.sv
// Randomized + directed bench for ex_mem_reg, checked against a behavioural
// model that applies the register's rules with plain arithmetic.
module tb_ex_mem_reg;

  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             reset;
  logic             stall, flush, valid_in;
  logic [1:0]       WB_in;
  logic [3:0]       MEM_in;
  logic [2:0]       AluzeroCtr;
  logic             RegDst;
  logic [4:0]       Ins20_in, Ins15_in;
  logic [31:0]      alu_result;
  logic             alu_zero;
  logic [31:0]      B_in, nextAddress_in, imm_in;
  logic [25:0]      tar_in;
  logic             valid_out;
  logic [1:0]       WB_out;
  logic [3:0]       MEM_out;
  logic [31:0]      alu_result_out, B_out;
  logic [4:0]       writeReg_out;
  logic             pcSrc_out;
  logic [31:0]      redirect_out;
  logic [CNT_W-1:0] taken_cnt;

  int checks = 0;
  int errors = 0;

  // Expected state of the MEM-side register file.
  logic [31:0] e_valid, e_wb, e_mem, e_alu, e_b, e_wr, e_pcsrc, e_redir;
  int          e_cnt;

  ex_mem_reg #(.CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .valid_in(valid_in), .WB_in(WB_in), .MEM_in(MEM_in),
    .AluzeroCtr(AluzeroCtr), .RegDst(RegDst), .Ins20_in(Ins20_in),
    .Ins15_in(Ins15_in), .alu_result(alu_result), .alu_zero(alu_zero),
    .B_in(B_in), .nextAddress_in(nextAddress_in), .imm_in(imm_in),
    .tar_in(tar_in), .valid_out(valid_out), .WB_out(WB_out),
    .MEM_out(MEM_out), .alu_result_out(alu_result_out), .B_out(B_out),
    .writeReg_out(writeReg_out), .pcSrc_out(pcSrc_out),
    .redirect_out(redirect_out), .taken_cnt(taken_cnt)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic checkAll();
    checkOutput("valid_out", {31'd0, valid_out}, e_valid);
    checkOutput("WB_out", {30'd0, WB_out}, e_wb);
    checkOutput("MEM_out", {28'd0, MEM_out}, e_mem);
    checkOutput("alu_result_out", alu_result_out, e_alu);
    checkOutput("B_out", B_out, e_b);
    checkOutput("writeReg_out", {27'd0, writeReg_out}, e_wr);
    checkOutput("pcSrc_out", {31'd0, pcSrc_out}, e_pcsrc);
    checkOutput("redirect_out", redirect_out, e_redir);
    checkOutput("taken_cnt", 32'(taken_cnt), 32'(e_cnt));
  endtask

  task automatic modelClear(input bit keep_cnt);
    e_valid = 0; e_wb = 0; e_mem = 0; e_alu = 0; e_b = 0;
    e_wr = 0; e_pcsrc = 0; e_redir = 0;
    if (!keep_cnt) e_cnt = 0;
  endtask

  function automatic bit modelTaken();
    bit negative;
    negative = ($signed(alu_result) < 0);
    case (int'(AluzeroCtr))
      1: return alu_zero;
      2: return !alu_zero;
      3: return alu_zero || negative;
      4: return !alu_zero && !negative;
      5: return negative;
      6: return !negative;
      7: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic modelEdge();
    longint unsigned sum;
    bit t;
    if (!reset) modelClear(0);
    else if (flush) modelClear(1);
    else if (!stall) begin
      t = modelTaken() && valid_in;
      e_valid = valid_in;
      e_wb    = valid_in ? WB_in : 0;
      e_mem   = valid_in ? MEM_in : 0;
      e_alu   = alu_result;
      e_b     = B_in;
      e_wr    = RegDst ? Ins15_in : Ins20_in;
      e_pcsrc = t;
      if (AluzeroCtr == 3'd7)
        e_redir = (nextAddress_in & 32'hF000_0000) + (32'(tar_in) * 4);
      else begin
        sum = longint'(nextAddress_in) + longint'(imm_in) * 4;
        e_redir = sum[31:0];
      end
      if (t && e_cnt < CNT_MAX) e_cnt++;
    end
  endtask

  // One clock edge: DUT and model both consume the current inputs.
  task automatic applyStimulus();
    @(posedge clk);
    #1;
    modelEdge();
    checkAll();
  endtask

  task automatic randomData();
    WB_in = 2'($urandom); MEM_in = 4'($urandom); AluzeroCtr = 3'($urandom);
    RegDst = 1'($urandom); Ins20_in = 5'($urandom); Ins15_in = 5'($urandom);
    alu_result = $urandom; alu_zero = 1'($urandom); B_in = $urandom;
    nextAddress_in = $urandom; imm_in = $urandom; tar_in = 26'($urandom);
  endtask

  task automatic asyncResetPulse();
    #2;
    reset = 1'b0;
    #1;
    modelClear(0);
    checkAll();
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic setBranch(input logic [2:0] code, input logic [31:0] res,
                           input logic zero);
    valid_in = 1'b1; stall = 1'b0; flush = 1'b0;
    AluzeroCtr = code; alu_result = res; alu_zero = zero;
  endtask

  initial begin
    modelClear(0);
    reset = 1'b0; stall = 1'b0; flush = 1'b0; valid_in = 1'b1;
    randomData();
    #1;
    checkAll();
    for (int i = 0; i < 3; i++) begin
      randomData();
      applyStimulus();
    end

    // Release reset and load a plain R-type result.
    reset = 1'b1;
    randomData();
    setBranch(3'd0, 32'h1234, 1'b0);
    RegDst = 1'b1; Ins15_in = 5'd7; WB_in = 2'b11;
    applyStimulus();
    checkOutput("t1_alu", alu_result_out, 32'h1234);
    checkOutput("t1_wr", {27'd0, writeReg_out}, 32'd7);

    // beq taken / not taken.
    setBranch(3'd1, 32'd0, 1'b1);
    nextAddress_in = 32'h0040_0010; imm_in = 32'hFFFF_FFFC;
    applyStimulus();
    checkOutput("t2_redirect", redirect_out, 32'h0040_0000);
    checkOutput("t2_pcsrc", {31'd0, pcSrc_out}, 32'd1);
    checkOutput("t2_cnt", 32'(taken_cnt), 32'd1);
    alu_zero = 1'b0;
    applyStimulus();
    checkOutput("t2_pcsrc_nt", {31'd0, pcSrc_out}, 32'd0);

    // Jump and sign-based codes.
    setBranch(3'd7, $urandom, 1'($urandom));
    nextAddress_in = 32'h8000_0004; tar_in = 26'h0000100;
    applyStimulus();
    checkOutput("t3_jump", redirect_out, 32'h8000_0400);
    setBranch(3'd5, 32'hFFFF_FFFF, 1'b0);
    applyStimulus();
    checkOutput("t3_bltz", {31'd0, pcSrc_out}, 32'd1);
    setBranch(3'd4, 32'd0, 1'b1);
    applyStimulus();
    checkOutput("t3_bgtz", {31'd0, pcSrc_out}, 32'd0);

    // Stall holds everything, flush wins over stall.
    setBranch(3'd1, 32'd0, 1'b1);
    WB_in = 2'b10; MEM_in = 4'b0101;
    applyStimulus();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      randomData();
      applyStimulus();
    end
    flush = 1'b1;
    applyStimulus();
    checkOutput("t4_flush_pcsrc", {31'd0, pcSrc_out}, 32'd0);
    flush = 1'b0; stall = 1'b0;

    // Bubble with a jump code must not redirect or write back.
    setBranch(3'd7, 32'd0, 1'b0);
    valid_in = 1'b0; WB_in = 2'b11;
    applyStimulus();
    checkOutput("t5_wb", {30'd0, WB_out}, 32'd0);

    // Saturation, then asynchronous reset between edges.
    for (int i = 0; i < 20; i++) begin
      randomData();
      setBranch(3'd7, $urandom, 1'b0);
      applyStimulus();
    end
    checkOutput("t6_sat", 32'(taken_cnt), 32'(CNT_MAX));
    asyncResetPulse();
    checkOutput("t6_reset_cnt", 32'(taken_cnt), 32'd0);

    // Random traffic with occasional stall, flush and reset pulses.
    for (int i = 0; i < 300; i++) begin
      randomData();
      valid_in = ($urandom % 4) != 0;
      stall    = ($urandom % 5) == 0;
      flush    = ($urandom % 8) == 0;
      applyStimulus();
      if (i % 97 == 96) asyncResetPulse();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
